// File: rtl/riscv_top.sv
// Single-cycle RV32I-subset core: PC, instruction ROM, datapath (DP1) with register
// file (DP1.RF) and ALU, and a word-addressed data RAM. One instruction retires per clock.

module riscv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regfile [0:31];

  // NOTE: registers are architectural state and clear on reset; the data RAM
  // in the top level is intentionally never reset so it survives a core reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      // NOTE: non-blocking, so a same-cycle read of wa still returns the old value.
      regfile[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regfile[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regfile[ra2];
endmodule

module riscv_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_next,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  output logic        wb_en,
  output logic [31:0] wb_data
);
  typedef enum logic [6:0] {
    OP_LOAD = 7'h03, OP_IMM = 7'h13, OP_STORE = 7'h23, OP_REG = 7'h33,
    OP_LUI  = 7'h37, OP_BRANCH = 7'h63, OP_JAL = 7'h6F
  } opcode_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, pc_plus4;
  logic        reg_write;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;

  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign alt    = instr[30];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign pc_plus4 = pc + 32'd4;

  riscv_regfile RF (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (reg_write),
    .ra1  (rs1),
    .ra2  (rs2),
    .wa   (rd),
    .wd   (wb_data),
    .rd1  (rs1_val),
    .rd2  (rs2_val)
  );

  function automatic alu_op_e funct_to_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      3'd7:    return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Decode; encodings outside the supported subset fall through as NOPs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    reg_write = 1'b0;
    dmem_we   = 1'b0;
    alu_op    = ALU_ADD;
    alu_b     = rs2_val;
    wb_sel    = WB_ALU;
    pc_next   = pc_plus4;
    case (opcode_e'(instr[6:0]))
      OP_REG: if (funct3 != 3'd3 && (!alt || funct3 == 3'd0)) begin
        reg_write = 1'b1;
        alu_op    = funct_to_alu(funct3, alt);
      end
      OP_IMM: if (funct3 != 3'd3 && !(funct3 == 3'd5 && alt)) begin
        reg_write = 1'b1;
        alu_op    = funct_to_alu(funct3, 1'b0);
        alu_b     = imm_i;
      end
      OP_LOAD: begin
        reg_write = 1'b1;
        alu_b     = imm_i;
        wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        dmem_we = 1'b1;
        alu_b   = imm_s;
      end
      OP_BRANCH: if ((funct3 == 3'd0 && rs1_val == rs2_val) ||
                     (funct3 == 3'd1 && rs1_val != rs2_val)) begin
        pc_next = pc + imm_b;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        pc_next   = pc + imm_j;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rs1_val + alu_b;
      ALU_SUB: alu_res = rs1_val - alu_b;
      ALU_AND: alu_res = rs1_val & alu_b;
      ALU_OR:  alu_res = rs1_val | alu_b;
      ALU_XOR: alu_res = rs1_val ^ alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLL: alu_res = rs1_val << alu_b[4:0];
      ALU_SRL: alu_res = rs1_val >> alu_b[4:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_MEM:  wb_data = dmem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      WB_IMM:  wb_data = imm_u;
      default: wb_data = alu_res;
    endcase
  end

  assign wb_en      = reg_write && (rd != 5'd0);
  assign dmem_addr  = alu_res;
  assign dmem_wdata = rs2_val;
endmodule

module riscv_top #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] display_data
);
  localparam int IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0]        imem [IMEM_DEPTH];
  logic [31:0]        dmem [DMEM_DEPTH];
  logic [31:0]        pc, pc_next, instr;
  logic [31:0]        dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic               dmem_we, wb_en;
  logic [IMEM_AW-1:0] imem_idx;
  logic [DMEM_AW-1:0] dmem_idx;

  // ROM image; words beyond the loaded image stay zero and decode as NOPs.
  initial begin
    for (int i = 0; i < int'(IMEM_DEPTH); i++) imem[i] = '0;
  end

  assign imem_idx   = IMEM_AW'((pc >> 2) % IMEM_DEPTH);
  assign dmem_idx   = DMEM_AW'((dmem_addr >> 2) % DMEM_DEPTH);
  assign instr      = imem[imem_idx];
  assign dmem_rdata = dmem[dmem_idx];

  riscv_datapath DP1 (
    .clk       (clk),
    .rst_n     (reset),
    .pc        (pc),
    .instr     (instr),
    .dmem_rdata(dmem_rdata),
    .pc_next   (pc_next),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we   (dmem_we),
    .wb_en     (wb_en),
    .wb_data   (wb_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      display_data <= '0;
    end else begin
      pc <= pc_next;
      if (wb_en) display_data <= wb_data;
    end
  end

  // Stores are suppressed while the core is held in reset.
  always_ff @(posedge clk) begin
    if (dmem_we && reset) dmem[dmem_idx] <= dmem_wdata;
  end
endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: an instruction-level ISA model checked against the core every
// cycle, plus directed expectations worked out by hand for the test program.

module tb_riscv_top;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] display_data;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OPI = 7'h13;
  localparam logic [6:0] OPL = 7'h03;

  logic [31:0] prog   [64];
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc, m_disp;

  riscv_top #(.IMEM_FILE("")) dut (
    .clk         (clk),
    .reset       (reset),
    .display_data(display_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [11:0] v;
    v = imm[11:0];
    return {v, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
    logic [11:0] v;
    v = imm[11:0];
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input int off);
    logic [12:0] v;
    v = off[12:0];
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input int off);
    logic [20:0] v;
    v = off[20:0];
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F};
  endfunction

  // ---------------- ISA-level reference model ----------------
  function automatic logic [31:0] isa_op(input logic [2:0] f3, input logic is_sub,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return is_sub ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> b[4:0];
      3'd6: return a | b;
      3'd7: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_disp = 32'h0;
    for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, res, nxt, ii, is, ib, ij;
    logic [2:0]  f3;
    logic        wr;
    logic [4:0]  rd;
    ins = prog[(m_pc >> 2) % 64];
    a   = m_reg[ins[19:15]];
    b   = m_reg[ins[24:20]];
    f3  = ins[14:12];
    rd  = ins[11:7];
    ii  = 32'($signed(ins[31:20]));
    is  = 32'($signed({ins[31:25], ins[11:7]}));
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    nxt = m_pc + 32'd4;
    wr  = 1'b0;
    res = 32'h0;
    case (ins[6:0])
      7'h33: if (f3 != 3'd3 && (!ins[30] || f3 == 3'd0)) begin
        wr = 1'b1; res = isa_op(f3, ins[30], a, b);
      end
      7'h13: if (f3 != 3'd3 && !(f3 == 3'd5 && ins[30])) begin
        wr = 1'b1; res = isa_op(f3, 1'b0, a, ii);
      end
      7'h03: begin wr = 1'b1; res = m_dmem[((a + ii) >> 2) % 64]; end
      7'h23: m_dmem[((a + is) >> 2) % 64] = b;
      7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b)) nxt = m_pc + ib;
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
      default: ;
    endcase
    if (wr && rd != 5'd0) begin
      m_reg[rd] = res;
      m_disp    = res;
    end
    m_pc = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // Every running cycle: PC, all registers and display_data against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("pc", dut.pc, m_pc);
        for (int r = 0; r < 32; r++)
          check($sformatf("x%0d", r), dut.DP1.RF.regfile[r], m_reg[r]);
        check("display_data", display_data, m_disp);
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0]  = enc_i(OPI, 3'd0, 5'd1, 5'd0, 5);
    prog[1]  = enc_i(OPI, 3'd0, 5'd2, 5'd0, 3);
    prog[2]  = enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
    prog[3]  = enc_r(7'h20, 3'd0, 5'd4, 5'd1, 5'd2);
    prog[4]  = enc_s(5'd3, 5'd0, 0);
    prog[5]  = enc_i(OPL, 3'd2, 5'd5, 5'd0, 0);
    prog[6]  = enc_b(3'd0, 5'd1, 5'd1, 8);
    prog[7]  = enc_i(OPI, 3'd0, 5'd6, 5'd0, 1);
    prog[8]  = enc_b(3'd1, 5'd1, 5'd1, 8);
    prog[9]  = enc_j(5'd7, 8);
    prog[10] = enc_i(OPI, 3'd0, 5'd6, 5'd0, 2);
    prog[11] = enc_i(OPI, 3'd0, 5'd0, 5'd0, 9);
    prog[12] = enc_i(OPI, 3'd0, 5'd8, 5'd0, -1);
    prog[13] = enc_r(7'h00, 3'd2, 5'd9, 5'd8, 5'd1);
    prog[14] = enc_r(7'h00, 3'd4, 5'd10, 5'd1, 5'd2);
    prog[15] = enc_r(7'h00, 3'd6, 5'd11, 5'd1, 5'd2);
    prog[16] = enc_r(7'h00, 3'd7, 5'd12, 5'd1, 5'd2);
    prog[17] = enc_r(7'h00, 3'd1, 5'd13, 5'd1, 5'd2);
    prog[18] = enc_r(7'h00, 3'd5, 5'd14, 5'd8, 5'd1);
    prog[19] = enc_i(OPI, 3'd2, 5'd15, 5'd8, 0);
    prog[20] = enc_r(7'h00, 3'd2, 5'd16, 5'd1, 5'd8);
    prog[21] = enc_i(OPI, 3'd7, 5'd17, 5'd8, 'hF0);
    prog[22] = enc_i(OPI, 3'd6, 5'd18, 5'd1, -16);
    prog[23] = enc_i(OPI, 3'd4, 5'd19, 5'd1, -1);
    prog[24] = enc_i(OPI, 3'd1, 5'd20, 5'd1, 31);
    prog[25] = enc_i(OPI, 3'd5, 5'd21, 5'd20, 31);
    prog[26] = {20'h12345, 5'd22, 7'h37};
    prog[27] = enc_r(7'h00, 3'd0, 5'd23, 5'd8, 5'd21);
    prog[28] = enc_s(5'd22, 5'd1, 4);
    prog[29] = enc_i(OPL, 3'd2, 5'd24, 5'd1, 4);
    prog[30] = 32'hFFFF_FFFF;
    prog[31] = enc_s(5'd1, 5'd0, 256);
    prog[32] = enc_i(OPL, 3'd2, 5'd25, 5'd0, 0);
    prog[33] = enc_b(3'd0, 5'd0, 5'd0, 8);
    prog[34] = enc_i(OPI, 3'd0, 5'd27, 5'd0, 7);
    prog[35] = enc_j(5'd26, -140);

    #1;
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

    // Held in reset across a clock edge.
    #14;
    check("reset pc", dut.pc, 32'h0);
    check("reset display", display_data, 32'h0);
    for (int r = 0; r < 32; r++)
      check($sformatf("reset x%0d", r), dut.DP1.RF.regfile[r], 32'h0);
    #7 reset = 1'b1;

    edges(4);
    check("x1 addi", dut.DP1.RF.regfile[1], 32'd5);
    check("x2 addi", dut.DP1.RF.regfile[2], 32'd3);
    check("x3 add",  dut.DP1.RF.regfile[3], 32'd8);
    check("x4 sub",  dut.DP1.RF.regfile[4], 32'd2);
    check("display after sub", display_data, 32'd2);
    edges(1);
    check("dmem0 sw", dut.dmem[0], 32'd8);
    check("display after sw", display_data, 32'd2);
    edges(1);
    check("x5 lw", dut.DP1.RF.regfile[5], 32'd8);
    edges(1);
    check("pc beq taken", dut.pc, 32'h20);
    edges(1);
    check("pc bne not taken", dut.pc, 32'h24);
    edges(1);
    check("pc jal", dut.pc, 32'h2C);
    check("x7 link", dut.DP1.RF.regfile[7], 32'h28);
    edges(1);
    check("x0 write ignored", dut.DP1.RF.regfile[0], 32'h0);
    check("display after x0 write", display_data, 32'h28);
    edges(2);
    check("x8 addi -1", dut.DP1.RF.regfile[8], 32'hFFFF_FFFF);
    check("x9 slt", dut.DP1.RF.regfile[9], 32'd1);
    edges(21);
    check("pc jal back", dut.pc, 32'h0);
    check("x26 link", dut.DP1.RF.regfile[26], 32'h90);
    check("x6 skipped", dut.DP1.RF.regfile[6], 32'h0);
    check("x27 skipped", dut.DP1.RF.regfile[27], 32'h0);
    check("x10 xor", dut.DP1.RF.regfile[10], 32'd6);
    check("x11 or",  dut.DP1.RF.regfile[11], 32'd7);
    check("x12 and", dut.DP1.RF.regfile[12], 32'd1);
    check("x13 sll", dut.DP1.RF.regfile[13], 32'd40);
    check("x14 srl", dut.DP1.RF.regfile[14], 32'h07FF_FFFF);
    check("x15 slti", dut.DP1.RF.regfile[15], 32'd1);
    check("x16 slt", dut.DP1.RF.regfile[16], 32'd0);
    check("x17 andi", dut.DP1.RF.regfile[17], 32'h0000_00F0);
    check("x18 ori", dut.DP1.RF.regfile[18], 32'hFFFF_FFF5);
    check("x19 xori", dut.DP1.RF.regfile[19], 32'hFFFF_FFFA);
    check("x20 slli", dut.DP1.RF.regfile[20], 32'h8000_0000);
    check("x21 srli", dut.DP1.RF.regfile[21], 32'd1);
    check("x22 lui", dut.DP1.RF.regfile[22], 32'h1234_5000);
    check("x23 wrap", dut.DP1.RF.regfile[23], 32'h0);
    check("dmem2 sw", dut.dmem[2], 32'h1234_5000);
    check("x24 lw", dut.DP1.RF.regfile[24], 32'h1234_5000);
    check("x25 lw wrapped", dut.DP1.RF.regfile[25], 32'd5);

    // Second pass, then asynchronous reset between clock edges.
    edges(8);
    #2 reset = 1'b0;
    #1;
    check("async reset pc", dut.pc, 32'h0);
    check("async reset display", display_data, 32'h0);
    check("async reset x1", dut.DP1.RF.regfile[1], 32'h0);
    check("async reset x26", dut.DP1.RF.regfile[26], 32'h0);
    check("reset keeps dmem0", dut.dmem[0], 32'd8);
    edges(1);
    check("reset hold pc", dut.pc, 32'h0);
    check("reset hold dmem2", dut.dmem[2], 32'h1234_5000);
    #2 reset = 1'b1;
    edges(4);
    check("restart x4", dut.DP1.RF.regfile[4], 32'd2);
    check("restart pc", dut.pc, 32'h10);
    edges(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
